// File: rtl/spi_wb_host_master.sv
// SPI mode-0 master that turns single-word Wishbone read/write requests into
// A1/A2 command frames, then polls for and parses the A3/A4 response frames
// returned by a remote SPI-to-Wishbone bridge.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; cs_n high, sclk low
// SETUP | cs_n low, CLK_DIV cycles before the first SCLK edge
// REQ   | shifting out the 7 or 11 request bytes
// POLL  | clocking 00 bytes until the response header is seen
// BODY  | receiving count, address echo and (for reads) data
// HOLD  | sclk low for CLK_DIV cycles before cs_n is released
// GAP   | cs_n high for CS_GAP cycles before the next frame
module spi_wb_host_master #(
   parameter int         CLK_DIV    = 4,
   parameter int         MAX_POLL   = 16,
   parameter int         CS_GAP     = 4,
   parameter logic [7:0] READ_REQ   = 8'hA1,
   parameter logic [7:0] WRITE_REQ  = 8'hA2,
   parameter logic [7:0] READ_RESP  = 8'hA3,
   parameter logic [7:0] WRITE_RESP = 8'hA4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_spi_sclk,
   output logic        o_spi_cs_n,
   output logic        o_spi_mosi,
   input  logic        i_spi_miso,
   output logic        o_busy
);

   // One counter serves SCLK half-periods, SETUP/HOLD waits and the CS gap.
   localparam int CNT_W = $clog2(CLK_DIV + CS_GAP + 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CS_GAP - 1);
   localparam int POLL_W = $clog2(MAX_POLL + 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLL - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_REQ,
      S_POLL,
      S_BODY,
      S_HOLD,
      S_GAP
   } state_t;

   state_t            state_q;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_q;
   logic [3:0]        byte_q;
   logic [7:0]        tx_q;
   logic [7:0]        rx_q;
   logic [POLL_W-1:0] poll_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic              sclk_q;
   logic              cs_n_q;
   logic              mosi_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [31:0]       rsp_rdata_q;

   logic [7:0]        req_first_d;
   logic [7:0]        req_next_d;
   logic [7:0]        echo_byte_d;
   logic [7:0]        exp_hdr_d;
   logic [3:0]        last_req_d;
   logic [3:0]        last_body_d;

   // Request frame byte at position idx: header, count 00 01, addr, wdata.
   function automatic logic [7:0] req_byte(input logic [3:0] idx, input logic we,
                                           input logic [31:0] addr, input logic [31:0] wdata);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         4'd0:    b = we ? WRITE_REQ : READ_REQ;
         4'd1:    b = 8'h00;
         4'd2:    b = 8'h01;
         4'd3:    b = addr[31:24];
         4'd4:    b = addr[23:16];
         4'd5:    b = addr[15:8];
         4'd6:    b = addr[7:0];
         4'd7:    b = wdata[31:24];
         4'd8:    b = wdata[23:16];
         4'd9:    b = wdata[15:8];
         4'd10:   b = wdata[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Frame bookkeeping derived from the latched request and byte position.
   always_comb begin
      req_first_d = req_byte(4'd0, we_q, addr_q, wdata_q);
      req_next_d  = req_byte(byte_q + 4'd1, we_q, addr_q, wdata_q);
      exp_hdr_d   = we_q ? WRITE_RESP : READ_RESP;
      last_req_d  = we_q ? 4'd10 : 4'd6;
      last_body_d = we_q ? 4'd5 : 4'd9;
      echo_byte_d = 8'h00;
      case (byte_q)
         4'd2:    echo_byte_d = addr_q[31:24];
         4'd3:    echo_byte_d = addr_q[23:16];
         4'd4:    echo_byte_d = addr_q[15:8];
         4'd5:    echo_byte_d = addr_q[7:0];
         default: echo_byte_d = 8'h00;
      endcase
   end

   // Sequencer, byte engine and response registers in one clocked process.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         poll_q      <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (i_req_valid) begin
                  we_q    <= i_req_we;
                  addr_q  <= i_req_addr;
                  wdata_q <= i_req_wdata;
                  poll_q  <= '0;
                  err_q   <= 1'b0;
                  rdata_q <= '0;
                  cnt_q   <= DIV_LOAD;
                  cs_n_q  <= 1'b0;
                  state_q <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt_q == '0) begin
                  cnt_q   <= DIV_LOAD;
                  bit_q   <= '0;
                  byte_q  <= '0;
                  tx_q    <= req_first_d;
                  mosi_q  <= req_first_d[7];
                  state_q <= S_REQ;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_REQ, S_POLL, S_BODY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q  <= DIV_LOAD;
                  sclk_q <= ~sclk_q;
                  if (!sclk_q) begin
                     rx_q <= {rx_q[6:0], i_spi_miso};
                  end else if (bit_q != 3'd7) begin
                     bit_q  <= bit_q + 3'd1;
                     tx_q   <= {tx_q[6:0], 1'b0};
                     mosi_q <= tx_q[6];
                  end else begin
                     // Last falling edge of a byte: rx_q holds the full byte and the
                     // next byte's MSB goes out on this same edge.
                     bit_q  <= '0;
                     tx_q   <= 8'h00;
                     mosi_q <= 1'b0;
                     if (state_q == S_REQ) begin
                        if (byte_q == last_req_d) begin
                           state_q <= S_POLL;
                        end else begin
                           byte_q <= byte_q + 4'd1;
                           tx_q   <= req_next_d;
                           mosi_q <= req_next_d[7];
                        end
                     end else if (state_q == S_POLL) begin
                        if (rx_q == exp_hdr_d) begin
                           byte_q  <= '0;
                           state_q <= S_BODY;
                        end else begin
                           poll_q <= poll_q + 1'b1;
                           if (poll_q == POLL_LAST) begin
                              err_q   <= 1'b1;
                              state_q <= S_HOLD;
                           end
                        end
                     end else begin
                        if ((byte_q >= 4'd2) && (byte_q <= 4'd5) && (rx_q != echo_byte_d)) begin
                           err_q <= 1'b1;
                        end
                        if (byte_q >= 4'd6) begin
                           rdata_q <= {rdata_q[23:0], rx_q};
                        end
                        if (byte_q == last_body_d) begin
                           state_q <= S_HOLD;
                        end else begin
                           byte_q <= byte_q + 4'd1;
                        end
                     end
                  end
               end
            end
            S_HOLD: begin
               if (cnt_q == '0) begin
                  cs_n_q      <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= err_q;
                  rsp_rdata_q <= (err_q || we_q) ? 32'h0 : rdata_q;
                  cnt_q       <= GAP_LOAD;
                  state_q     <= S_GAP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_GAP: begin
               if (cnt_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready = (state_q == S_IDLE);
   assign o_busy      = (state_q != S_IDLE);
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_spi_sclk  = sclk_q;
   assign o_spi_cs_n  = cs_n_q;
   assign o_spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_wb_host_master.sv
// Bench for spi_wb_host_master: a behavioural SPI slave replays scripted MISO
// bytes and logs MOSI bytes; expected responses go through a scoreboard queue.
module tb_spi_wb_host_master;

   localparam int CS_GAP_T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_ready, rsp_valid, rsp_err, sclk, cs_n, mosi, busy;
   logic [31:0] rsp_rdata;
   logic        miso = 1'b1;

   logic        v2 = 1'b0, v5 = 1'b0;
   logic        r2, r5, rv2, rv5, e2, e5, s2, s5, c2, c5, m2, m5, b2, b5;
   logic [31:0] d2, d5;

   always #5 clk = ~clk;

   spi_wb_host_master u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_spi_sclk(sclk), .o_spi_cs_n(cs_n), .o_spi_mosi(mosi), .i_spi_miso(miso),
      .o_busy(busy));

   spi_wb_host_master #(.CLK_DIV(2)) u_div2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v2), .o_req_ready(r2),
      .i_req_we(1'b0), .i_req_addr(32'h0), .i_req_wdata(32'h0),
      .o_rsp_valid(rv2), .o_rsp_rdata(d2), .o_rsp_err(e2),
      .o_spi_sclk(s2), .o_spi_cs_n(c2), .o_spi_mosi(m2), .i_spi_miso(1'b1),
      .o_busy(b2));

   spi_wb_host_master #(.CLK_DIV(5)) u_div5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v5), .o_req_ready(r5),
      .i_req_we(1'b0), .i_req_addr(32'h0), .i_req_wdata(32'h0),
      .o_rsp_valid(rv5), .o_rsp_rdata(d5), .o_rsp_err(e5),
      .o_spi_sclk(s5), .o_spi_cs_n(c5), .o_spi_mosi(m5), .i_spi_miso(1'b1),
      .o_busy(b5));

   int n_tests = 0;
   int n_fail  = 0;
   int rsp_cnt = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb_q[$];

   // Behavioural mode-0 slave
   logic [7:0] miso_bytes [0:63];
   logic [7:0] mosi_log   [0:63];
   int         s_idx = 0, s_bit = 0, s_nbytes = 0;
   logic [7:0] s_rx = 8'h00;

   always @(negedge cs_n) begin
      s_idx = 0;
      s_bit = 0;
      miso  = miso_bytes[0][7];
   end
   always @(posedge cs_n) s_nbytes = s_idx;
   always @(posedge sclk) if (cs_n === 1'b0) begin
      s_rx  = {s_rx[6:0], mosi};
      s_bit = s_bit + 1;
   end
   always @(negedge sclk) if (cs_n === 1'b0) begin
      if (s_bit == 8) begin
         if (s_idx < 63) begin
            mosi_log[s_idx] = s_rx;
            s_idx = s_idx + 1;
         end
         s_bit = 0;
         miso  = miso_bytes[s_idx][7];
      end else begin
         miso = miso_bytes[s_idx][7 - s_bit];
      end
   end

   always @(posedge clk) if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;

   task automatic set_script(input int req_len, input int miss, input logic [7:0] hdr,
                             input logic [31:0] echo, input logic [31:0] data, input bit stuck);
      int p;
      for (int i = 0; i < 64; i++) miso_bytes[i] = 8'hFF;
      if (!stuck) begin
         p = req_len + miss;
         miso_bytes[p]   = hdr;
         miso_bytes[p+1] = 8'h00;
         miso_bytes[p+2] = 8'h01;
         for (int i = 0; i < 4; i++) begin
            miso_bytes[p+3+i] = echo[31-8*i -: 8];
            miso_bytes[p+7+i] = data[31-8*i -: 8];
         end
      end
   endtask

   // Waits for IDLE, presents one request, then scrambles the inputs.
   task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output bit got);
      int n;
      got = 1'b0;
      n = 0;
      while (req_ready !== 1'b1 && n < 8000) begin
         @(posedge clk); #1; n++;
      end
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk); #1;
      got       = (req_ready === 1'b0);
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 32'hFFFF_F0F0;
      req_wdata = 32'h5A5A_5A5A;
   endtask

   task automatic wait_rsp(output bit got);
      got = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(posedge clk); #1;
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({sclk, cs_n, mosi, req_ready, rsp_valid, rsp_err, busy} !== 7'b0101000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b expected 0101000", {sclk, cs_n, mosi, req_ready, rsp_valid, rsp_err, busy});
      end
      n_tests++;
      if (rsp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_write();
      exp_t e;
      bit got;
      logic [7:0] fr [0:10];
      bit bad;
      fr = '{8'hA2, 8'h00, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      set_script(11, 1, 8'hA4, 32'h0000_0400, 32'h0, 1'b0);
      sb_q.push_back('{1'b0, 32'h0});
      issue_req(1'b1, 32'h0000_0400, 32'h0000_0001, got);
      wait_rsp(got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL write_rsp: got no rsp_valid expected pulse");
         sb_q.delete();
      end else begin
         e = sb_q.pop_front();
         n_tests++;
         if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL write_result: got err=%b rdata=%h expected err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
         end
         n_tests++;
         if (s_nbytes !== 19) begin
            n_fail++;
            $display("FAIL write_bytes: got %0d expected 19", s_nbytes);
         end
         bad = 1'b0;
         for (int i = 0; i < 11; i++) if (mosi_log[i] !== fr[i]) bad = 1'b1;
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL write_mosi: got %h %h %h %h %h %h %h %h %h %h %h expected A2 00 01 00 00 04 00 00 00 00 01",
                     mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4], mosi_log[5],
                     mosi_log[6], mosi_log[7], mosi_log[8], mosi_log[9], mosi_log[10]);
         end
         @(posedge clk); #1;
         n_tests++;
         if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_pulse_width: got %b expected 0", rsp_valid);
         end
      end
   endtask

   task automatic test_read();
      exp_t e;
      bit got;
      logic [7:0] fr [0:6];
      bit bad;
      fr = '{8'hA1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      set_script(7, 3, 8'hA3, 32'h0, 32'hDEAD_BEEF, 1'b0);
      sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
      issue_req(1'b0, 32'h0000_0000, 32'h1111_1111, got);
      wait_rsp(got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL read_rsp: got no rsp_valid expected pulse");
         sb_q.delete();
      end else begin
         e = sb_q.pop_front();
         n_tests++;
         if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL read_result: got err=%b rdata=%h expected err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
         end
         n_tests++;
         if (s_nbytes !== 21) begin
            n_fail++;
            $display("FAIL read_bytes: got %0d expected 21", s_nbytes);
         end
         bad = 1'b0;
         for (int i = 0; i < 7; i++) if (mosi_log[i] !== fr[i]) bad = 1'b1;
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL read_mosi: got %h %h %h %h %h %h %h expected A1 00 01 00 00 00 00",
                     mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4], mosi_log[5], mosi_log[6]);
         end
      end
   endtask

   task automatic test_poll_timeout();
      exp_t e;
      bit got;
      set_script(7, 0, 8'h00, 32'h0, 32'h0, 1'b1);
      sb_q.push_back('{1'b1, 32'h0});
      issue_req(1'b0, 32'h0000_0080, 32'h0, got);
      wait_rsp(got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL timeout_rsp: got no rsp_valid expected pulse");
         sb_q.delete();
      end else begin
         e = sb_q.pop_front();
         n_tests++;
         if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL timeout_result: got err=%b rdata=%h expected err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
         end
         n_tests++;
         if (s_nbytes - 7 !== 16) begin
            n_fail++;
            $display("FAIL timeout_polls: got %0d expected 16", s_nbytes - 7);
         end
      end
   endtask

   task automatic test_echo_mismatch();
      exp_t e;
      bit got;
      set_script(7, 0, 8'hA3, 32'h0000_0204, 32'h1234_5678, 1'b0);
      sb_q.push_back('{1'b1, 32'h0});
      issue_req(1'b0, 32'h0000_0200, 32'h0, got);
      wait_rsp(got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL echo_rsp: got no rsp_valid expected pulse");
         sb_q.delete();
      end else begin
         e = sb_q.pop_front();
         n_tests++;
         if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL echo_result: got err=%b rdata=%h expected err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit got;
      int n;
      set_script(11, 0, 8'hA4, 32'h0000_0010, 32'h0, 1'b0);
      sb_q.push_back('{1'b0, 32'h0});
      sb_q.push_back('{1'b0, 32'h0});
      n = 0;
      while (req_ready !== 1'b1 && n < 8000) begin
         @(posedge clk); #1; n++;
      end
      req_we    = 1'b1;
      req_addr  = 32'h0000_0010;
      req_wdata = 32'hCAFE_F00D;
      req_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_rsp(got);
         n_tests++;
         if (!got) begin
            n_fail++;
            $display("FAIL b2b_rsp%0d: got no rsp_valid expected pulse", k);
            sb_q.delete();
            break;
         end
         e = sb_q.pop_front();
         n_tests++;
         if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got err=%b rdata=%h expected err=%b rdata=%h", k, rsp_err, rsp_rdata, e.err, e.rdata);
         end
         if (k == 0) begin
            n = 0;
            while (cs_n === 1'b1 && n < 50) begin
               @(posedge clk); #1; n++;
            end
            req_valid = 1'b0;
            n_tests++;
            if (n < CS_GAP_T + 1 || n >= 50) begin
               n_fail++;
               $display("FAIL b2b_cs_gap: got %0d cycles expected >= %0d", n, CS_GAP_T + 1);
            end
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      exp_t e;
      bit got;
      int n, rc0;
      set_script(7, 0, 8'hA3, 32'h0000_0300, 32'h1122_3344, 1'b0);
      issue_req(1'b0, 32'h0000_0300, 32'h0, got);
      n = 0;
      while (s_idx < 2 && n < 4000) begin
         @(posedge clk); #1; n++;
      end
      rc0 = rsp_cnt;
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({cs_n, sclk, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_abort: got cs_n/sclk/busy=%b expected 100", {cs_n, sclk, busy});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      n_tests++;
      if (rsp_cnt !== rc0) begin
         n_fail++;
         $display("FAIL reset_no_rsp: got %0d pulses expected 0", rsp_cnt - rc0);
      end
      sb_q.push_back('{1'b0, 32'h1122_3344});
      issue_req(1'b0, 32'h0000_0300, 32'h0, got);
      wait_rsp(got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL reset_recover_rsp: got no rsp_valid expected pulse");
         sb_q.delete();
      end else begin
         e = sb_q.pop_front();
         n_tests++;
         if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL reset_recover_result: got err=%b rdata=%h expected err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
         end
      end
   endtask

   task automatic test_sclk_period(input int div);
      int n, bad_n;
      logic cur, prev;
      bit bad, got;
      @(posedge clk); #1;
      if (div == 2) v2 = 1'b1; else v5 = 1'b1;
      @(posedge clk); #1;
      v2 = 1'b0;
      v5 = 1'b0;
      n = 0;
      cur = (div == 2) ? s2 : s5;
      while (cur !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
         cur = (div == 2) ? s2 : s5;
      end
      bad = (n >= 200);
      bad_n = 0;
      for (int k = 0; k < 6; k++) begin
         prev = cur;
         n = 0;
         do begin
            @(posedge clk); #1; n++;
            cur = (div == 2) ? s2 : s5;
         end while (cur === prev && n < 40);
         if (n != div) begin
            bad = 1'b1;
            bad_n = n;
         end
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL sclk_half_div%0d: got %0d cycles expected %0d", div, bad_n, div);
      end
      got = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (((div == 2) ? rv2 : rv5) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!got || ((div == 2) ? {e2, d2} : {e5, d5}) !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL div%0d_timeout: got valid=%b err/rdata=%h expected 1 100000000", div, got,
                  (div == 2) ? {e2, d2} : {e5, d5});
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         miso_bytes[i] = 8'hFF;
         mosi_log[i]   = 8'h00;
      end
      test_reset();
      test_write();
      test_read();
      test_poll_timeout();
      test_echo_mismatch();
      test_back_to_back();
      test_reset_mid_frame();
      test_sclk_period(2);
      test_sclk_period(5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
